reg_bank_8x16: RTL

Eight-entry, 16-bit register bank that stores the register-file contents and drives the eight data inputs of the downstream 16-bit 8:1 read multiplexer. One synchronous write port with address decode; all eight register values are presented in parallel every cycle. A request-driven clear sequencer walks the bank one register per cycle to a programmable value, with busy/done status, so software can reinitialise the file without a global reset.

---
 rtl/reg_bank_8x16.sv | 104 ++++++++++
 1 files changed

// File: rtl/reg_bank_8x16.sv
// rtl/reg_bank_8x16.sv - 8x16 register bank with write port and sequenced clear
module reg_bank_8x16 #(
    parameter int               WIDTH   = 16,
    parameter logic [WIDTH-1:0] CLR_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [2:0]       waddr,
    input  logic [WIDTH-1:0] wdata,
    output logic             wr_ack,
    input  logic             clr_req,
    output logic             busy,
    output logic             clr_done,
    output logic [WIDTH-1:0] Q0,
    output logic [WIDTH-1:0] Q1,
    output logic [WIDTH-1:0] Q2,
    output logic [WIDTH-1:0] Q3,
    output logic [WIDTH-1:0] Q4,
    output logic [WIDTH-1:0] Q5,
    output logic [WIDTH-1:0] Q6,
    output logic [WIDTH-1:0] Q7
);

    typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

    state_t           state, state_next;
    logic [2:0]       idx, idx_next;
    logic             wr_en;
    logic [2:0]       wr_addr;
    logic [WIDTH-1:0] wr_val;
    logic             wr_ack_next;
    logic [WIDTH-1:0] regs [8];

    // The clear walk and the host write share one register write port.
    always_comb begin
        state_next  = state;
        idx_next    = idx;
        wr_en       = 1'b0;
        wr_addr     = waddr;
        wr_val      = wdata;
        wr_ack_next = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (we) begin
                    wr_en       = 1'b1;
                    wr_ack_next = 1'b1;
                end
                state_next = clr_req ? CLEAR : IDLE;
                idx_next   = 3'd0;
            end
            CLEAR: begin
                wr_en    = 1'b1;
                wr_addr  = idx;
                wr_val   = CLR_VAL;
                idx_next = idx + 3'd1;
                if (idx == 3'd7) begin
                    state_next = DONE;
                end
            end
            default: begin
                state_next = IDLE;
                idx_next   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            idx      <= 3'd0;
            wr_ack   <= 1'b0;
            busy     <= 1'b0;
            clr_done <= 1'b0;
        end else begin
            state    <= state_next;
            idx      <= idx_next;
            wr_ack   <= wr_ack_next;
            // Status lags the state by one edge so it lines up with the register updates.
            busy     <= (state == CLEAR);
            clr_done <= (state == DONE);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[wr_addr] <= wr_val;
        end
    end

    assign Q0 = regs[0];
    assign Q1 = regs[1];
    assign Q2 = regs[2];
    assign Q3 = regs[3];
    assign Q4 = regs[4];
    assign Q5 = regs[5];
    assign Q6 = regs[6];
    assign Q7 = regs[7];

endmodule
